// File: rtl/md_sequencer.sv
// ----------------------------------------------------------------------------
// md_sequencer
//   Multi-cycle multiply/divide unit with HI/LO registers, placed beside the
//   EX-stage ALU. A long op (MULT/MULTU/DIV/DIVU, plus MADD/MADDU when
//   MD_MADD_EN is defined) computes its 64-bit result on the start edge,
//   holds it in a pending register while busy counts down, and commits it to
//   HI/LO on the last busy edge. MTHI/MTLO write HI/LO directly when idle.
//
//   Optional feature macro: MD_MADD_EN (adds MADD/MADDU accumulate ops 6/7).
//
//   Ports:
//     clk       in   1   system clock, rising edge
//     reset     in   1   synchronous active-high reset
//     start_E   in   1   EX-stage instruction is a mult/div-unit op
//     md_op_E   in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MADDU
//     srcA_E    in  32   forwarded rs operand
//     srcB_E    in  32   forwarded rt operand
//     md_use_D  in   1   D-stage instruction uses the unit or HI/LO
//     hi_sel    in   1   read select: 1 = HI, 0 = LO
//     md_out    out 32   selected HI or LO
//     busy      out  1   operation in flight
//     stall_md  out  1   stall request to the hazard unit
//
//   state  | meaning
//   S_IDLE | no operation pending; accepts long ops and MTHI/MTLO
//   S_RUN  | long op in flight; counter counts down to commit
// ----------------------------------------------------------------------------
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] srcA_E,
    input  logic [31:0] srcB_E,
    input  logic        md_use_D,
    input  logic        hi_sel,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        stall_md
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    state_t      r_state,   w_state_nxt;
    logic [3:0]  r_cnt,     w_cnt_nxt;
    logic [31:0] r_hi,      w_hi_nxt;
    logic [31:0] r_lo,      w_lo_nxt;
    logic [63:0] r_pend,    w_pend_nxt;
    logic        r_pend_ok, w_pend_ok_nxt;

    logic        w_long_op;
    logic        w_is_div;
    logic        w_div_signed;
    logic        w_div_zero;
    logic [63:0] w_mul_s;
    logic [63:0] w_mul_u;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_result;

    // ------------------------------------------------------------------------
    // Op classification
    // ------------------------------------------------------------------------
`ifdef MD_MADD_EN
    assign w_long_op = (md_op_E <= OP_DIVU) || (md_op_E == OP_MADD) || (md_op_E == OP_MADDU);
`else
    assign w_long_op = (md_op_E <= OP_DIVU);
`endif
    assign w_is_div     = (md_op_E == OP_DIV) || (md_op_E == OP_DIVU);
    assign w_div_signed = (md_op_E == OP_DIV);
    assign w_div_zero   = (srcB_E == 32'd0);

    // ------------------------------------------------------------------------
    // Arithmetic, evaluated on the start edge only
    // ------------------------------------------------------------------------
    // Explicit 64-bit extension keeps the products independent of signedness rules.
    assign w_mul_s = {{32{srcA_E[31]}}, srcA_E} * {{32{srcB_E[31]}}, srcB_E};
    assign w_mul_u = {32'd0, srcA_E} * {32'd0, srcB_E};

    // Signed divide is done on magnitudes: this gives truncation toward zero,
    // and 0x80000000 / -1 naturally wraps back to 0x80000000 with remainder 0.
    // A zero divisor is replaced by 1 so no X/undefined value is produced; the
    // result is discarded at commit anyway.
    always_comb begin
        w_num = srcA_E;
        w_den = srcB_E;
        if (w_div_signed) begin
            if (srcA_E[31]) w_num = 32'd0 - srcA_E;
            if (srcB_E[31]) w_den = 32'd0 - srcB_E;
        end
        if (w_div_zero) w_den = 32'd1;
    end

    assign w_q_mag = w_num / w_den;
    assign w_r_mag = w_num % w_den;
    assign w_quot  = (w_div_signed && (srcA_E[31] ^ srcB_E[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = (w_div_signed && srcA_E[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_result = 64'd0;
        case (md_op_E)
            OP_MULT:  w_result = w_mul_s;
            OP_MULTU: w_result = w_mul_u;
            OP_DIV,
            OP_DIVU:  w_result = {w_rem, w_quot};
`ifdef MD_MADD_EN
            // Accumulate base is HI/LO as seen on the start edge.
            OP_MADD:  w_result = {r_hi, r_lo} + w_mul_s;
            OP_MADDU: w_result = {r_hi, r_lo} + w_mul_u;
`endif
            default:  w_result = 64'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend    <= 64'd0;
            r_pend_ok <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_ok <= w_pend_ok_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_nxt    = r_pend;
        w_pend_ok_nxt = r_pend_ok;
        busy          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_E) begin
                    if (w_long_op) begin
                        w_state_nxt   = S_RUN;
                        w_cnt_nxt     = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        w_pend_nxt    = w_result;
                        w_pend_ok_nxt = !(w_is_div && w_div_zero);
                    end else if (md_op_E == OP_MTHI) begin
                        w_hi_nxt = srcA_E;
                    end else if (md_op_E == OP_MTLO) begin
                        w_lo_nxt = srcA_E;
                    end
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                w_cnt_nxt = r_cnt - 4'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot lock the unit.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                    if (r_pend_ok) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign md_out   = hi_sel ? r_hi : r_lo;
    assign stall_md = md_use_D & (busy | start_E);

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_E;
    logic [2:0]  md_op_E;
    logic [31:0] srcA_E;
    logic [31:0] srcB_E;
    logic        md_use_D;
    logic        hi_sel;
    logic [31:0] md_out;
    logic        busy;
    logic        stall_md;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] q_exp[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_E  (start_E),
        .md_op_E  (md_op_E),
        .srcA_E   (srcA_E),
        .srcB_E   (srcB_E),
        .md_use_D (md_use_D),
        .hi_sel   (hi_sel),
        .md_out   (md_out),
        .busy     (busy),
        .stall_md (stall_md)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic get_hilo(output logic [31:0] hi, output logic [31:0] lo);
        hi_sel = 1'b1;
        #1;
        hi = md_out;
        hi_sel = 1'b0;
        #1;
        lo = md_out;
    endtask

    task automatic do_long(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int ncyc,
                           input logic [31:0] eh, input logic [31:0] el);
        int          n;
        logic [31:0] last_lo;
        logic [31:0] h;
        logic [31:0] l;
        logic [63:0] e;
        q_exp.push_back({eh, el});
        start_E = 1'b1;
        md_op_E = op;
        srcA_E  = a;
        srcB_E  = b;
        step();
        start_E = 1'b0;
        hi_sel  = 1'b0;
        n       = 0;
        last_lo = m_lo;
        while (busy === 1'b1 && n < 40) begin
            n++;
            #1;
            last_lo = md_out;
            step();
        end
        check({tag, "_busy_len"}, 32'(n), 32'(ncyc));
        check({tag, "_commit_cycle_old_lo"}, last_lo, m_lo);
        e = q_exp.pop_front();
        get_hilo(h, l);
        check({tag, "_hi"}, h, e[63:32]);
        check({tag, "_lo"}, l, e[31:0]);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    initial begin
        int          n;
        logic [31:0] h;
        logic [31:0] l;

        reset    = 1'b1;
        start_E  = 1'b0;
        md_op_E  = 3'd0;
        srcA_E   = 32'd0;
        srcB_E   = 32'd0;
        md_use_D = 1'b0;
        hi_sel   = 1'b0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        step();
        step();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(stall_md), 32'd0);
        get_hilo(h, l);
        check("reset_hi", h, 32'd0);
        check("reset_lo", l, 32'd0);

        do_long("mult",    3'd0, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_long("multu",   3'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA);
        do_long("div",     3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_long("divu_z",  3'd3, 32'd7,         32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_long("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        do_long("div_nd",  3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        do_long("divu",    3'd3, 32'd100,       32'd7, 10, 32'd2, 32'd14);

        // Stall window plus a stray start mid-busy.
        q_exp.push_back({32'd0, 32'd35});
        md_use_D = 1'b1;
        start_E  = 1'b1;
        md_op_E  = 3'd0;
        srcA_E   = 32'd5;
        srcB_E   = 32'd7;
        #1;
        check("stall_start_cycle", 32'(stall_md), 32'd1);
        step();
        start_E = 1'b0;
        srcA_E  = 32'd100;
        srcB_E  = 32'd100;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            check("stall_busy", 32'(stall_md), 32'd1);
            start_E = (n == 2);
            step();
        end
        start_E = 1'b0;
        check("stall_busy_len", 32'(n), 32'd5);
        check("stall_after_busy", 32'(stall_md), 32'd0);
        md_use_D = 1'b0;
        get_hilo(h, l);
        begin
            logic [63:0] e;
            e = q_exp.pop_front();
            check("stall_mult_hi", h, e[63:32]);
            check("stall_mult_lo", l, e[31:0]);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end

        // MTHI while idle.
        start_E = 1'b1;
        md_op_E = 3'd4;
        srcA_E  = 32'h1234_5678;
        step();
        start_E = 1'b0;
        check("mthi_busy", 32'(busy), 32'd0);
        get_hilo(h, l);
        check("mthi_hi", h, 32'h1234_5678);
        check("mthi_lo_kept", l, 32'd35);

        // MTLO while busy with a divide-by-zero: nothing may change.
        start_E = 1'b1;
        md_op_E = 3'd3;
        srcA_E  = 32'd9;
        srcB_E  = 32'd0;
        step();
        md_op_E = 3'd5;
        srcA_E  = 32'hDEAD_BEEF;
        step();
        start_E = 1'b0;
        check("mtlo_busy_still", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("mtlo_busy_len", 32'(n + 1), 32'd10);
        get_hilo(h, l);
        check("mtlo_ign_hi", h, 32'h1234_5678);
        check("mtlo_ign_lo", l, 32'd35);

`ifdef MD_MADD_EN
        start_E = 1'b1;
        md_op_E = 3'd4;
        srcA_E  = 32'd0;
        step();
        md_op_E = 3'd5;
        srcA_E  = 32'd10;
        step();
        start_E = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd10;
        do_long("madd", 3'd6, 32'hFFFF_FFFF, 32'd4, 5, 32'd0, 32'd6);
`else
        start_E = 1'b1;
        md_op_E = 3'd6;
        srcA_E  = 32'hFFFF_FFFF;
        srcB_E  = 32'd4;
        step();
        start_E = 1'b0;
        check("op6_busy", 32'(busy), 32'd0);
        step();
        check("op6_busy_later", 32'(busy), 32'd0);
        get_hilo(h, l);
        check("op6_hi", h, 32'h1234_5678);
        check("op6_lo", l, 32'd35);
`endif

        // Reset in the third busy cycle of a DIV aborts it.
        start_E = 1'b1;
        md_op_E = 3'd2;
        srcA_E  = 32'd100;
        srcB_E  = 32'd7;
        step();
        start_E = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        get_hilo(h, l);
        check("rst_mid_hi", h, 32'd0);
        check("rst_mid_lo", l, 32'd0);
        repeat (15) step();
        check("rst_late_busy", 32'(busy), 32'd0);
        get_hilo(h, l);
        check("rst_late_hi", h, 32'd0);
        check("rst_late_lo", l, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
